// File: rtl/alu_op_feeder.sv
// alu_op_feeder: buffers (function, operand) ops in a small FIFO and, on
// Start, issues them to the 4-bit ALU one per cycle on registered outputs.
// While not issuing, the ALU hold opcode (2'b11) is driven with operand 0.
// Optional feature macro: ALU_FEEDER_PAUSE_EN adds a Pause input that stalls
// issuing while in RUN.
module alu_op_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic             In_valid,
  input  logic [3:0]       In_data,
  input  logic [1:0]       In_func,
  output logic             In_ready,
  input  logic             Start,
  output logic [3:0]       Data,
  output logic [1:0]       Function,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Op_count
`ifdef ALU_FEEDER_PAUSE_EN
  ,
  input  logic             Pause
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop, start_acc, paused;
  logic [3:0]    next_data;
  logic [1:0]    next_func;

`ifdef ALU_FEEDER_PAUSE_EN
  assign paused = Pause;
`else
  assign paused = 1'b0;
`endif

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign In_ready  = !full;
  // Full FIFO refuses a push even when it pops in the same cycle.
  assign push      = In_valid && !full;
  assign pop       = (state == ST_RUN) && !empty && !paused;
  assign start_acc = (state == ST_IDLE) && Start;
  assign Busy      = (state == ST_RUN);
  assign Done      = (state == ST_DONE);

  // Next state and next ALU operand/function; hold opcode unless popping.
  always_comb begin
    next_state = state;
    next_data  = 4'h0;
    next_func  = 2'b11;
    case (state)
      ST_IDLE: if (Start) next_state = ST_RUN;
      ST_RUN: begin
        if (!paused) begin
          if (!empty) {next_func, next_data} = mem[rd_ptr];
          else        next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {In_func, In_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register, registered ALU outputs and saturating issue counter.
  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      state    <= ST_IDLE;
      Data     <= 4'h0;
      Function <= 2'b11;
      Op_count <= '0;
    end else begin
      state    <= next_state;
      Data     <= next_data;
      Function <= next_func;
      if (start_acc)                    Op_count <= '0;
      else if (pop && Op_count != '1)   Op_count <= Op_count + 1'b1;
    end
  end

endmodule
